// File: rtl/sgdmac_pkg.sv
// sgdmac_pkg: shared AXI constants and the AR command record for the SG-DMA.
package sgdmac_pkg;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B = 3'b010;
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_cmd_t;
endpackage

// File: rtl/sgdmac_rr_picker.sv
// sgdmac_rr_picker: combinational round-robin pick of the first eligible at or after ptr.
module sgdmac_rr_picker #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);
  assign any = |eligible;
  always_comb begin
    int j;
    logic found;
    grant = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && eligible[j]) begin
        found = 1'b1;
        grant[j] = 1'b1;
        idx = PW'(j);
      end
    end
  end
endmodule

// File: rtl/sgdmac_ar_scheduler.sv
// sgdmac_ar_scheduler: round-robin AR arbiter with per-requester outstanding caps
// and rid-steered rready for the shared R channel.
module sgdmac_ar_scheduler
  import sgdmac_pkg::*;
#(
  parameter int N_REQ           = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_WIDTH        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid_i,
  output logic [N_REQ-1:0]      req_ready_o,
  input  logic [N_REQ*32-1:0]   req_addr_i,
  input  logic [N_REQ*4-1:0]    req_len_i,
  input  logic [N_REQ*3-1:0]    req_size_i,
  input  logic [N_REQ*2-1:0]    req_burst_i,
  input  logic [N_REQ-1:0]      req_rready_i,
  output logic [ID_WIDTH-1:0]   arid_o,
  output logic [31:0]           araddr_o,
  output logic [3:0]            arlen_o,
  output logic [2:0]            arsize_o,
  output logic [1:0]            arburst_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [ID_WIDTH-1:0]   rid_i,
  input  logic                  rvalid_i,
  input  logic                  rlast_i,
  output logic                  rready_o,
  output logic                  idle_o,
  output logic                  err_o
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic EMPTY = 1'b0;
  localparam logic HOLD  = 1'b1;

  logic                 state, load, any, rid_ok;
  logic [PW-1:0]        ptr, idx;
  logic [N_REQ-1:0]     eligible, grant, dec, zero;
  logic [CW-1:0]        cnt [N_REQ];
  ar_cmd_t              cmd, sel;

  sgdmac_rr_picker #(.N(N_REQ), .PW(PW)) u_picker (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant),
    .idx      (idx),
    .any      (any)
  );

  assign load        = (state == EMPTY) || arready_i;
  assign req_ready_o = (rst_n && load) ? grant : '0;
  assign sel         = {req_addr_i[32*idx +: 32], req_len_i[4*idx +: 4],
                        req_size_i[3*idx +: 3], req_burst_i[2*idx +: 2]};
  assign rid_ok      = int'(rid_i) < N_REQ;

  // Unmapped ids are drained so a stray burst cannot wedge the shared R channel.
  always_comb begin
    rready_o = 1'b1;
    for (int i = 0; i < N_REQ; i++)
      if (int'(rid_i) == i) rready_o = req_rready_i[i];
  end

  always_comb begin
    eligible = '0;
    dec = '0;
    zero = '0;
    for (int i = 0; i < N_REQ; i++) begin
      zero[i] = cnt[i] == '0;
      eligible[i] = req_valid_i[i] && (cnt[i] < CW'(MAX_OUTSTANDING));
      dec[i] = rvalid_i && rready_o && rlast_i && (int'(rid_i) == i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      cmd <= '0;
      arid_o <= '0;
      ptr <= '0;
    end else if (load) begin
      state <= any ? HOLD : EMPTY;
      if (any) begin
        cmd <= sel;
        arid_o <= ID_WIDTH'(idx);
        ptr <= (idx == PW'(N_REQ - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  // A grant and a returning last beat in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
      err_o <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (req_ready_o[i] && !dec[i]) cnt[i] <= cnt[i] + 1'b1;
        else if (dec[i] && !req_ready_o[i] && !zero[i]) cnt[i] <= cnt[i] - 1'b1;
      err_o <= err_o || (rvalid_i && !rid_ok) || |(dec & ~req_ready_o & zero);
    end
  end

  assign arvalid_o = state;
  assign araddr_o  = cmd.addr;
  assign arlen_o   = cmd.len;
  assign arsize_o  = cmd.size;
  assign arburst_o = cmd.burst;
  assign idle_o    = (&zero) && !state;
endmodule

// File: tb/tb_sgdmac_ar_scheduler.sv
// tb_sgdmac_ar_scheduler: directed table vectors plus multi-cycle sequences for the AR scheduler.
module tb_sgdmac_ar_scheduler;
  import sgdmac_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_rready;
  logic [63:0] req_addr;
  logic [7:0]  req_len;
  logic [5:0]  req_size;
  logic [3:0]  req_burst;
  logic [3:0]  arid, rid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready, rvalid, rlast, rready, idle, err;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] rid;
    logic [1:0] rr;
    logic [1:0] v;
    logic       exp_rready;
    logic [1:0] exp_rdy;
  } vec_t;
  vec_t tv [8];

  always #10 clk = ~clk;

  sgdmac_ar_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_len_i(req_len), .req_size_i(req_size),
    .req_burst_i(req_burst), .req_rready_i(req_rready),
    .arid_o(arid), .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize),
    .arburst_o(arburst), .arvalid_o(arvalid), .arready_i(arready),
    .rid_i(rid), .rvalid_i(rvalid), .rlast_i(rlast), .rready_o(rready),
    .idle_o(idle), .err_o(err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_rready = '0;
    arready = 1'b0;
    rvalid = 1'b0;
    rlast = 1'b0;
    rid = '0;
    req_addr = {32'h2000_0000, 32'h1000_0000};
    req_len = {4'h7, 4'h3};
    req_size = {SIZE_4B, SIZE_4B};
    req_burst = {BURST_INCR, BURST_INCR};
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    tv[0] = '{4'd0, 2'b01, 2'b00, 1'b1, 2'b00};
    tv[1] = '{4'd0, 2'b10, 2'b01, 1'b0, 2'b01};
    tv[2] = '{4'd1, 2'b10, 2'b10, 1'b1, 2'b10};
    tv[3] = '{4'd1, 2'b01, 2'b11, 1'b0, 2'b01};
    tv[4] = '{4'd2, 2'b00, 2'b11, 1'b1, 2'b01};
    tv[5] = '{4'd3, 2'b00, 2'b10, 1'b1, 2'b10};
    tv[6] = '{4'd1, 2'b11, 2'b00, 1'b1, 2'b00};
    tv[7] = '{4'd0, 2'b00, 2'b11, 1'b0, 2'b01};

    clear_inputs();
    rst_n = 1'b0;
    req_valid = 2'b11;
    tick();
    chk("rst_arvalid", arvalid, 0);
    chk("rst_idle", idle, 1);
    chk("rst_err", err, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arid", arid, 0);
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Combinational steering and first-pick from pointer 0, all within one clock phase.
    for (int i = 0; i < 8; i++) begin
      rid = tv[i].rid;
      req_rready = tv[i].rr;
      req_valid = tv[i].v;
      #1;
      chk($sformatf("tv%0d_rready", i), rready, tv[i].exp_rready);
      chk($sformatf("tv%0d_req_ready", i), req_ready, tv[i].exp_rdy);
    end
    req_valid = '0;
    rid = '0;
    tick();
    chk("tv_idle", idle, 1);

    do_reset();
    arready = 1'b1;
    req_valid = 2'b11;
    req_rready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      rvalid = k > 0;
      rlast = k > 0;
      rid = 4'((k + 1) % 2);
      #5;
      chk($sformatf("rr%0d_req_ready", k), req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk($sformatf("rr%0d_arvalid", k), arvalid, 1);
      chk($sformatf("rr%0d_arid", k), arid, k % 2);
      chk($sformatf("rr%0d_araddr", k), araddr, (k % 2 == 0) ? 32'h1000_0000 : 32'h2000_0000);
      chk($sformatf("rr%0d_arlen", k), arlen, (k % 2 == 0) ? 4'h3 : 4'h7);
    end
    req_valid = '0;
    rvalid = 1'b1;
    rlast = 1'b1;
    rid = 4'd1;
    tick();
    rvalid = 1'b0;
    rlast = 1'b0;
    chk("rr_end_arvalid", arvalid, 0);
    chk("rr_end_idle", idle, 1);

    do_reset();
    req_valid = 2'b01;
    req_addr[31:0] = 32'hA000_0000;
    #5;
    chk("stall_first_ready", req_ready, 2'b01);
    tick();
    chk("stall_first_addr", araddr, 32'hA000_0000);
    req_addr[31:0] = 32'hB000_0000;
    for (int k = 0; k < 5; k++) begin
      #5;
      chk($sformatf("stall%0d_req_ready", k), req_ready, 0);
      tick();
      chk($sformatf("stall%0d_araddr", k), araddr, 32'hA000_0000);
      chk($sformatf("stall%0d_arvalid", k), arvalid, 1);
      chk($sformatf("stall%0d_idle", k), idle, 0);
    end
    arready = 1'b1;
    #5;
    chk("stall_release_ready", req_ready, 2'b01);
    tick();
    chk("stall_release_addr", araddr, 32'hB000_0000);
    chk("stall_release_arvalid", arvalid, 1);

    do_reset();
    req_valid = 2'b01;
    arready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #5;
      chk($sformatf("cap%0d_ready", k), req_ready, 2'b01);
      tick();
    end
    #5;
    chk("cap_full_ready", req_ready, 2'b00);
    tick();
    chk("cap_full_arvalid", arvalid, 0);
    req_valid = 2'b11;
    #5;
    chk("cap_req1_ready", req_ready, 2'b10);
    tick();
    chk("cap_req1_arid", arid, 1);
    req_valid = 2'b01;
    rvalid = 1'b1;
    rlast = 1'b1;
    rid = 4'd0;
    req_rready = 2'b01;
    #5;
    chk("cap_rlast_ready", req_ready, 2'b00);
    tick();
    rvalid = 1'b0;
    rlast = 1'b0;
    #5;
    chk("cap_regrant_ready", req_ready, 2'b01);
    tick();
    chk("cap_regrant_arid", arid, 0);
    chk("cap_regrant_arvalid", arvalid, 1);

    do_reset();
    req_valid = 2'b10;
    arready = 1'b1;
    req_rready = 2'b10;
    for (int k = 0; k < 2; k++) begin
      #5;
      chk($sformatf("same%0d_ready", k), req_ready, 2'b10);
      tick();
    end
    rvalid = 1'b1;
    rlast = 1'b1;
    rid = 4'd1;
    #5;
    chk("same_cycle_ready", req_ready, 2'b10);
    chk("same_cycle_rready", rready, 1);
    tick();
    rvalid = 1'b0;
    rlast = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #5;
      chk($sformatf("same_fill%0d_ready", k), req_ready, 2'b10);
      tick();
    end
    #5;
    chk("same_capped_ready", req_ready, 2'b00);
    chk("same_err", err, 0);

    do_reset();
    rvalid = 1'b1;
    rid = 4'd3;
    #5;
    chk("unmapped_rready", rready, 1);
    chk("unmapped_err_before", err, 0);
    tick();
    chk("unmapped_err", err, 1);
    rvalid = 1'b0;
    tick();
    chk("unmapped_err_sticky", err, 1);

    do_reset();
    chk("underflow_err_clear", err, 0);
    rvalid = 1'b1;
    rlast = 1'b1;
    rid = 4'd0;
    req_rready = 2'b01;
    #5;
    chk("underflow_rready", rready, 1);
    tick();
    rvalid = 1'b0;
    rlast = 1'b0;
    chk("underflow_err", err, 1);
    chk("underflow_idle", idle, 1);
    req_valid = 2'b01;
    tick();
    chk("hold_arvalid", arvalid, 1);
    chk("hold_idle", idle, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_arvalid", arvalid, 0);
    chk("midrst_araddr", araddr, 0);
    chk("midrst_arlen", arlen, 0);
    chk("midrst_err", err, 0);
    chk("midrst_idle", idle, 1);
    chk("midrst_req_ready", req_ready, 0);
    tick();
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
